// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: memory-op kinds, load/store funct3 codes and
// the memory-stage FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/half out of a read word and sign- or
// zero-extends it; purely combinational.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    b       = shifted[7:0];
    // Halves are picked on addr[1] only, so a misaligned half reads its aligned half.
    h       = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'd0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store over a single-outstanding req/ack bus, stalls the pipe while busy.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_m and suppresses misaligned requests.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  input  mem_op_t           mem_op_m,
  input  logic [2:0]        funct3_m,
  input  logic [31:0]       addr_m,
  input  logic [31:0]       alu_result_m,
  input  logic [31:0]       wdata_m,
  input  logic              rd_valid_e,
  input  logic [4:0]        rd_e,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata,
  output logic              mem_stall,
  output logic              rd_valid_m,
  output logic [4:0]        rd_m,
  output logic [31:0]       reg_d_m
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_m
`endif
);

  mem_state_t  state, state_nxt;
  logic [31:0] rdata_buf;
  logic [31:0] load_data;
  logic        mem_op;
  logic        issue;

  assign mem_op = (mem_op_m != MEM_NONE);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (funct3_m[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_m[0];
      default: misalign = (addr_m[1:0] != 2'b00);
    endcase
  end
  assign misalign_m = !reset && (state == IDLE) && mem_op && misalign;
  assign issue      = mem_op && !misalign;
`else
  assign issue = mem_op;
`endif

  always_comb begin
    state_nxt = state;
    dbus_req  = 1'b0;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          dbus_req  = 1'b1;
          mem_stall = 1'b1;
          state_nxt = dbus_ack ? DONE : BUSY;
        end
      end
      BUSY: begin
        dbus_req  = 1'b1;
        mem_stall = 1'b1;
        if (dbus_ack) state_nxt = DONE;
      end
      DONE: begin
        if (!halted) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      dbus_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rdata_buf <= 32'd0;
    end else begin
      state <= state_nxt;
      // Only an ack answering our own request is captured; stray acks are dropped.
      if (dbus_req && dbus_ack) rdata_buf <= dbus_rdata;
    end
  end

  // Request fields come straight from the EX/MEM register, which mem_stall freezes.
  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = wdata_m;
    case (funct3_m[1:0])
      2'b00: begin
        dbus_be    = 4'b0001 << addr_m[1:0];
        dbus_wdata = {4{wdata_m[7:0]}};
      end
      2'b01: begin
        dbus_be    = addr_m[1] ? 4'b1100 : 4'b0011;
        dbus_wdata = {2{wdata_m[15:0]}};
      end
      default: begin
        dbus_be    = 4'b1111;
        dbus_wdata = wdata_m;
      end
    endcase
  end

  assign dbus_we   = (mem_op_m == MEM_STORE);
  assign dbus_addr = {addr_m[ADDR_W-1:2], 2'b00};

  load_align u_load_align (
    .rdata  (rdata_buf),
    .addr   (addr_m[1:0]),
    .funct3 (funct3_m),
    .data   (load_data)
  );

  assign reg_d_m    = ((state == DONE) && (mem_op_m == MEM_LOAD)) ? load_data : alu_result_m;
  assign rd_m       = rd_e;
  assign rd_valid_m = !reset && rd_valid_e && (mem_op_m != MEM_STORE) &&
                      (state != BUSY) && !((state == IDLE) && mem_op);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written reset/halt
// sequences, then random transactions checked against a byte-level reference model.
module tb_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        halted;
  mem_op_t     mem_op_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m, alu_result_m, wdata_m;
  logic        rd_valid_e;
  logic [4:0]  rd_e;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_stall, rd_valid_m;
  logic [4:0]  rd_m;
  logic [31:0] reg_d_m;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_m;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .halted(halted), .mem_op_m(mem_op_m),
    .funct3_m(funct3_m), .addr_m(addr_m), .alu_result_m(alu_result_m),
    .wdata_m(wdata_m), .rd_valid_e(rd_valid_e), .rd_e(rd_e),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .rd_valid_m(rd_valid_m),
    .rd_m(rd_m), .reg_d_m(reg_d_m)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_m(misalign_m)
`endif
  );

  typedef struct {
    mem_op_t     op;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, alu, rdata;
    logic        rdv_e;
    logic [4:0]  rd;
    int          ack_delay, halt;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_regd;
    logic        e_rdv;
    int          e_stall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(mem_op_t op, logic [2:0] f3, logic [31:0] addr, wdata, alu,
                              logic rdv_e, logic [4:0] rd, logic [31:0] rdata,
                              int ack_delay, int halt, logic [3:0] e_be,
                              logic [31:0] e_wdata, e_regd, logic e_rdv, int e_stall);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.alu = alu;
    v.rdv_e = rdv_e; v.rd = rd; v.rdata = rdata; v.ack_delay = ack_delay; v.halt = halt;
    v.e_be = e_be; v.e_wdata = e_wdata; v.e_regd = e_regd; v.e_rdv = e_rdv; v.e_stall = e_stall;
    return v;
  endfunction

  // Reference model: access size in bytes and byte offset, then plain arithmetic.
  function automatic int nbytes(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int offs(logic [2:0] f3, logic [31:0] addr);
    int a = int'(addr % 4);
    if (nbytes(f3) == 1) return a;
    if (nbytes(f3) == 2) return (a / 2) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, logic [2:0] f3, logic [31:0] addr);
    int     nb = nbytes(f3);
    longint v  = (longint'(w) >> (8 * offs(f3, addr))) % (longint'(1) << (8 * nb));
    if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] addr);
    int nb = nbytes(f3);
    int m  = (nb == 4) ? 15 : (nb == 2) ? 3 : 1;
    m = m << offs(f3, addr);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    if (nbytes(f3) == 1) return (d % 256) * 32'h0101_0101;
    if (nbytes(f3) == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic run_vec(input string nm, input vec_t v);
    int          k;
    logic [3:0]  be0;
    logic [31:0] wd0, ad0;
    logic        we0, unstable, busy_bad, done_bad;
    mem_op_m = v.op; funct3_m = v.f3; addr_m = v.addr; wdata_m = v.wdata;
    alu_result_m = v.alu; rd_valid_e = v.rdv_e; rd_e = v.rd;
    halted = 1'b0; dbus_ack = 1'b0; dbus_rdata = $urandom;
    @(negedge clk);
    if (v.op == MEM_NONE) begin
      chk({nm, " req"}, 32'(dbus_req), 32'd0);
      chk({nm, " stall"}, 32'(mem_stall), 32'd0);
      chk({nm, " reg_d"}, reg_d_m, v.e_regd);
      chk({nm, " rd_valid"}, 32'(rd_valid_m), 32'(v.e_rdv));
      @(posedge clk); #1;
      return;
    end
    k = 0; unstable = 1'b0; busy_bad = 1'b0; done_bad = 1'b0;
    be0 = dbus_be; wd0 = dbus_wdata; ad0 = dbus_addr; we0 = dbus_we;
    while (dbus_req && k < 64) begin
      if ({dbus_be, dbus_wdata, dbus_addr, dbus_we} != {be0, wd0, ad0, we0}) unstable = 1'b1;
      if (!mem_stall || rd_valid_m) busy_bad = 1'b1;
      dbus_ack   = (k == v.ack_delay);
      dbus_rdata = (k == v.ack_delay) ? v.rdata : $urandom;
      k++;
      @(negedge clk);
    end
    chk({nm, " be"}, 32'(be0), 32'(v.e_be));
    chk({nm, " wdata"}, wd0, v.e_wdata);
    chk({nm, " we"}, 32'(we0), 32'(v.op == MEM_STORE));
    chk({nm, " addr"}, ad0, v.addr & ~32'h3);
    chk({nm, " stall_cycles"}, 32'(k), 32'(v.e_stall));
    chk({nm, " req_stable"}, 32'(unstable), 32'd0);
    chk({nm, " busy_outputs"}, 32'(busy_bad), 32'd0);
    // A stray ack with different data while in DONE must not disturb anything.
    dbus_ack = 1'b1; dbus_rdata = ~v.rdata;
    for (int h = 0; h < v.halt; h++) begin
      halted = 1'b1; #1;
      if (dbus_req || mem_stall) done_bad = 1'b1;
      if (v.op == MEM_LOAD && reg_d_m !== v.e_regd) done_bad = 1'b1;
      @(negedge clk);
    end
    halted = 1'b0; #1;
    if (dbus_req || mem_stall) done_bad = 1'b1;
    chk({nm, " done_quiet"}, 32'(done_bad), 32'd0);
    if (v.op == MEM_LOAD) chk({nm, " reg_d"}, reg_d_m, v.e_regd);
    chk({nm, " rd_valid"}, 32'(rd_valid_m), 32'(v.e_rdv));
    chk({nm, " rd"}, 32'(rd_m), 32'(v.rd));
    @(posedge clk); #1;
    dbus_ack = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(MEM_LOAD,  F3_W,  32'h100, 32'h0,        32'h1111, 1'b1, 5'd3,  32'hDEADBEEF, 0, 0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b1, 1);
    tbl[1]  = mk(MEM_LOAD,  F3_B,  32'h103, 32'h0,        32'h2222, 1'b1, 5'd4,  32'h80FF0000, 3, 0, 4'h8, 32'h0,        32'hFFFFFF80, 1'b1, 4);
    tbl[2]  = mk(MEM_LOAD,  F3_BU, 32'h103, 32'h0,        32'h2222, 1'b1, 5'd5,  32'h80FF0000, 3, 0, 4'h8, 32'h0,        32'h00000080, 1'b1, 4);
    tbl[3]  = mk(MEM_STORE, F3_H,  32'h202, 32'h1234ABCD, 32'h3333, 1'b1, 5'd6,  32'h0,        1, 0, 4'hC, 32'hABCDABCD, 32'h0,        1'b0, 2);
    tbl[4]  = mk(MEM_NONE,  F3_W,  32'h55,  32'h0,        32'h55,   1'b1, 5'd7,  32'h0,        0, 0, 4'hF, 32'h0,        32'h55,       1'b1, 0);
    tbl[5]  = mk(MEM_LOAD,  F3_W,  32'h300, 32'h0,        32'h4444, 1'b1, 5'd8,  32'h0BADF00D, 1, 2, 4'hF, 32'h0,        32'h0BADF00D, 1'b1, 2);
    tbl[6]  = mk(MEM_LOAD,  F3_H,  32'h102, 32'h0,        32'h5555, 1'b1, 5'd9,  32'h80017FFF, 0, 0, 4'hC, 32'h0,        32'hFFFF8001, 1'b1, 1);
    tbl[7]  = mk(MEM_LOAD,  F3_HU, 32'h100, 32'h0,        32'h6666, 1'b1, 5'd10, 32'h80017FFF, 2, 0, 4'h3, 32'h0,        32'h00007FFF, 1'b1, 3);
    tbl[8]  = mk(MEM_STORE, F3_B,  32'h001, 32'h000000A5, 32'h7777, 1'b1, 5'd11, 32'h0,        0, 0, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 1);
    tbl[9]  = mk(MEM_LOAD,  F3_H,  32'h101, 32'h0,        32'h8888, 1'b1, 5'd12, 32'h11228344, 0, 0, 4'h3, 32'h0,        32'hFFFF8344, 1'b1, 1);
    tbl[10] = mk(MEM_STORE, F3_W,  32'h3FC, 32'h89ABCDEF, 32'h9999, 1'b1, 5'd13, 32'h0,        0, 1, 4'hF, 32'h89ABCDEF, 32'h0,        1'b0, 1);
    tbl[11] = mk(MEM_LOAD,  F3_B,  32'h002, 32'h0,        32'hAAAA, 1'b0, 5'd14, 32'h00ABCDEF, 1, 0, 4'h4, 32'h0,        32'hFFFFFFAB, 1'b0, 2);

    // Reset state with a load pending on the inputs.
    reset = 1'b1; halted = 1'b0; mem_op_m = MEM_LOAD; funct3_m = F3_W; addr_m = 32'h10;
    alu_result_m = 32'h0; wdata_m = 32'h0; rd_valid_e = 1'b1; rd_e = 5'd1;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    @(negedge clk);
    chk("reset req", 32'(dbus_req), 32'd0);
    chk("reset stall", 32'(mem_stall), 32'd0);
    chk("reset rd_valid", 32'(rd_valid_m), 32'd0);
    mem_op_m = MEM_NONE;
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset while BUSY, then a late ack: must be ignored, nothing retires.
    mem_op_m = MEM_LOAD; funct3_m = F3_W; addr_m = 32'h400; rd_valid_e = 1'b1;
    alu_result_m = 32'h77; dbus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy req", 32'(dbus_req), 32'd1);
    chk("busy stall", 32'(mem_stall), 32'd1);
    reset = 1'b1; #1;
    chk("midreset req", 32'(dbus_req), 32'd0);
    chk("midreset rd_valid", 32'(rd_valid_m), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_op_m = MEM_NONE; dbus_ack = 1'b1; dbus_rdata = 32'hCAFEF00D; #1;
    chk("late_ack req", 32'(dbus_req), 32'd0);
    chk("late_ack stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    dbus_ack = 1'b0; #1;
    chk("post_ack stall", 32'(mem_stall), 32'd0);
    chk("post_ack reg_d", reg_d_m, 32'h77);
    @(posedge clk); #1;
    run_vec("after_reset", mk(MEM_LOAD, F3_W, 32'h404, 32'h0, 32'h0, 1'b1, 5'd2,
                              32'h13579BDF, 0, 0, 4'hF, 32'h0, 32'h13579BDF, 1'b1, 1));

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      vec_t        v;
      logic [2:0]  ld_f3[5];
      logic [2:0]  st_f3[3];
      int          sel;
      ld_f3[0] = F3_B; ld_f3[1] = F3_H; ld_f3[2] = F3_W; ld_f3[3] = F3_BU; ld_f3[4] = F3_HU;
      st_f3[0] = F3_B; st_f3[1] = F3_H; st_f3[2] = F3_W;
      sel = $urandom_range(0, 2);
      v.op        = (sel == 0) ? MEM_NONE : (sel == 1) ? MEM_LOAD : MEM_STORE;
      v.f3        = (v.op == MEM_STORE) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      v.addr      = $urandom; v.wdata = $urandom; v.alu = $urandom; v.rdata = $urandom;
      v.rdv_e     = 1'($urandom_range(0, 1));
      v.rd        = 5'($urandom_range(0, 31));
      v.ack_delay = $urandom_range(0, 4);
      v.halt      = $urandom_range(0, 2);
      v.e_be      = m_be(v.f3, v.addr);
      v.e_wdata   = m_wdata(v.f3, v.wdata);
      v.e_regd    = (v.op == MEM_LOAD) ? m_load(v.rdata, v.f3, v.addr) : v.alu;
      v.e_rdv     = v.rdv_e && (v.op != MEM_STORE);
      v.e_stall   = v.ack_delay + 1;
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline; sits between the execute/memory pipeline register and the memory/write-back pipeline register.
- Executes loads and stores over a single-outstanding req/ack data bus.
- Aligns and sign/zero-extends load data, and selects the write-back value (load data or ALU result).
- Asserts a stall to hold the pipeline while a bus transaction is in flight.

Parameters:
- ADDR_W, 32, width of the data-bus address; must be ≥ 2; upper bits above ADDR_W of addr_m are ignored.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- halted  input  1  downstream hold (from hazard/halt logic); instruction in M must not retire while high
- mem_op_m  input  2  mem_op_t: MEM_NONE / MEM_LOAD / MEM_STORE
- funct3_m  input  3  access size/sign (LB/LH/LW/LBU/LHU; SB/SH/SW)
- addr_m  input  32  effective address (ALU result)
- alu_result_m  input  32  non-load write-back value
- wdata_m  input  32  store data (rs2)
- rd_valid_e  input  1  instruction in M writes rd
- rd_e  input  5  destination register
- dbus_req  output  1  bus request, held until ack
- dbus_we  output  1  1 = store
- dbus_addr  output  ADDR_W  word-aligned address (addr_m[1:0] forced 0)
- dbus_be  output  4  byte enables
- dbus_wdata  output  32  store data replicated into lanes
- dbus_ack  input  1  bus completion, one cycle
- dbus_rdata  input  32  read word, valid with dbus_ack
- mem_stall  output  1  hold F/D/E/M stages
- rd_valid_m  output  1  to MEM/WB register
- rd_m  output  5  to MEM/WB register
- reg_d_m  output  32  to MEM/WB register

Behaviour:
- FSM states IDLE, BUSY, DONE; reset → IDLE, rdata_buf = 0.
- While reset is high: dbus_req = 0, mem_stall = 0, rd_valid_m = 0.
- IDLE, mem_op_m == MEM_NONE: no bus activity; mem_stall = 0; reg_d_m = alu_result_m.
- IDLE, mem op present:
  - dbus_req = 1 combinationally; mem_stall = 1.
  - dbus_ack in the same cycle: capture dbus_rdata → DONE (zero-wait path).
  - Otherwise → BUSY.
- BUSY: dbus_req, dbus_we, dbus_addr, dbus_be and dbus_wdata are held stable; mem_stall = 1. On dbus_ack: capture rdata → DONE.
- DONE:
  - dbus_req = 0; mem_stall = 0.
  - reg_d_m = extended rdata_buf for loads; stores force rd_valid_m = 0.
  - halted = 0 → IDLE. halted = 1 → stay in DONE; the access is never reissued.
- Latency: a load with ack at request cycle + N completes 1 + N cycles later; minimum 1 stall cycle per memory op.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1]·2.
  - Word: 1111.
- Store data is replicated into lanes: byte ×4, half ×2.
- Load extraction: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- rd_valid_m = rd_valid_e && mem_op_m != MEM_STORE && state != BUSY && !(IDLE && mem op). rd_m = rd_e always.
- dbus_ack while in IDLE with no request, or in DONE, is ignored.
- Reset mid-transaction abandons the access; a late ack after reset is ignored.
- Misaligned access without the feature: the low address bits still drive lane selection; the half/word access is performed on the aligned word, with no error.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_m (1 bit), asserted combinationally in IDLE when a half access has addr[0] = 1, or a word access has addr[1:0] ≠ 0.
  - The bus request is suppressed, mem_stall = 0, and rd_valid_m = 0.
- Undefined: the port is absent and misaligned accesses behave as above.

Decomposition:
- riscv_pkg holds:
  - mem_op_t enum.
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - mem_state_t enum (IDLE/BUSY/DONE).
- Sub-module load_align (combinational): rdata, addr[1:0], funct3 → 32-bit extended value.
- Store lane/byte-enable generation stays inline.

Test Plan:
- LW addr 0x100, ack same cycle, rdata 0xDEADBEEF → one stall cycle; reg_d_m = 0xDEADBEEF; rd_valid_m = 1 in DONE.
- LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles → dbus_be = 1000; mem_stall high 4 cycles; reg_d_m = 0xFFFFFF80. LBU gives 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD → dbus_be = 1100, dbus_wdata = 0xABCDABCD, dbus_we = 1; rd_valid_m = 0.
- ALU op, mem_op_m = NONE, alu_result_m = 0x55 → no dbus_req, mem_stall = 0, reg_d_m = 0x55 in the same cycle.
- Load in BUSY, reset pulsed, then ack arrives → back in IDLE, dbus_req = 0, ack ignored, no retire.
- LW completes to DONE with halted = 1 for 2 cycles → state stays in DONE, dbus_req stays 0 (no reissue), then retires when halted drops.
